// File: rtl/pipeline_control_unit_if.sv
// Bundle of host commands, hazard inputs and the pipeline control outputs for
// pipeline_control_unit. The master modport is the host/datapath side that
// drives commands and hazards. The slave modport is the controller.
interface pipeline_control_unit_if #(
   parameter int N_STAGES = 5,
   parameter int CNT_W    = 32
);
   // Host commands (single-cycle pulses)
   logic                cmd_run;
   logic                cmd_step;
   logic                cmd_pause;
   // Hazard and decode information from the datapath
   logic                load_use_hazard;
   logic                branch_taken;
   logic                halt_decoded;
   // Pipeline control
   logic                pc_en;
   logic [N_STAGES-1:0] stage_en;
   logic [N_STAGES-1:0] stage_flush;
   // Status and debug
   logic [2:0]          state;
   logic                halted;
   logic [CNT_W-1:0]    cycle_count;
   logic [CNT_W-1:0]    stall_count;

   modport master (
      output cmd_run, cmd_step, cmd_pause,
      output load_use_hazard, branch_taken, halt_decoded,
      input  pc_en, stage_en, stage_flush,
      input  state, halted, cycle_count, stall_count
   );

   modport slave (
      input  cmd_run, cmd_step, cmd_pause,
      input  load_use_hazard, branch_taken, halt_decoded,
      output pc_en, stage_en, stage_flush,
      output state, halted, cycle_count, stall_count
   );
endinterface

// File: rtl/pipeline_control_unit.sv
// Central pipeline controller for the MIPS core.
// - Produces per-stage enable and flush vectors from load-use and branch hazards.
// - Host run/step/pause FSM, with drain-then-halt on a decoded HALT instruction.
// - Optional cycle/stall counters: define PIPE_PERF_COUNTERS_EN to build them.
//   Without the macro both counter outputs are tied to zero and no counter
//   flops exist.
// - Legal N_STAGES range is 4..8. Stage 0 is IF, stage N_STAGES-1 is WB.
module pipeline_control_unit #(
   parameter int N_STAGES     = 5,
   parameter int HOLD_STAGES  = 2,
   parameter int BRANCH_STAGE = 3,
   parameter int CNT_W        = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   pipeline_control_unit_if.slave bus
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_STEP  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_HALT  = 3'd4;

   // Stage masks, derived once from the parameters.
   localparam logic [N_STAGES-1:0] ALL_MASK    = '1;
   localparam logic [N_STAGES-1:0] HOLD_MASK   = N_STAGES'((1 << HOLD_STAGES) - 1);
   localparam logic [N_STAGES-1:0] BUBBLE_MASK = N_STAGES'(1 << HOLD_STAGES);
   localparam logic [N_STAGES-1:0] BRANCH_MASK = N_STAGES'((1 << BRANCH_STAGE) - 1);
   // While draining, IF/ID are frozen and the HALT in ID turns into a bubble in stage 2.
   localparam logic [N_STAGES-1:0] DRAIN_EN    = ALL_MASK & ~N_STAGES'(3);
   localparam logic [N_STAGES-1:0] DRAIN_FLUSH = N_STAGES'(4);

   localparam logic [3:0] DRAIN_LEN = 4'(N_STAGES - 2);

   logic [2:0]          state_d, state_q;
   logic [3:0]          drain_d, drain_q;
   logic                halted_q;
   logic                pc_en;
   logic [N_STAGES-1:0] stage_en;
   logic [N_STAGES-1:0] stage_flush;
   logic                active;

   // RUN and STEP are the states where the pipeline advances under hazard control.
   assign active = (state_q == ST_RUN) || (state_q == ST_STEP);

   // Enable/flush vectors: registered state combined with same-cycle hazards.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the case infers a latch.
      pc_en       = 1'b0;
      stage_en    = '0;
      stage_flush = '0;
      case (state_q)
         ST_RUN, ST_STEP: begin
            if (bus.branch_taken) begin
               pc_en       = 1'b1;
               stage_en    = ALL_MASK;
               stage_flush = BRANCH_MASK;
            end else if (bus.load_use_hazard) begin
               pc_en       = 1'b0;
               stage_en    = ALL_MASK & ~HOLD_MASK;
               stage_flush = BUBBLE_MASK;
            end else begin
               pc_en       = 1'b1;
               stage_en    = ALL_MASK;
            end
         end
         ST_DRAIN: begin
            if (bus.branch_taken) begin
               // HALT was on the wrong path: the branch flush wins.
               pc_en       = 1'b1;
               stage_en    = ALL_MASK;
               stage_flush = BRANCH_MASK;
            end else begin
               stage_en    = DRAIN_EN;
               stage_flush = DRAIN_FLUSH;
            end
         end
         default: ;
      endcase
   end

   // Next-state and drain-counter logic.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         ST_IDLE: begin
            // Command priority: pause > run > step.
            if (bus.cmd_pause) state_d = ST_IDLE;
            else if (bus.cmd_run) state_d = ST_RUN;
            else if (bus.cmd_step) state_d = ST_STEP;
         end
         ST_RUN: begin
            if (bus.cmd_pause) begin
               state_d = ST_IDLE;
            end else if (bus.halt_decoded && !bus.branch_taken) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_LEN;
            end
         end
         ST_STEP: begin
            if (bus.halt_decoded && !bus.branch_taken) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_LEN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (bus.branch_taken) begin
               state_d = ST_RUN;
               drain_d = '0;
            end else begin
               drain_d = drain_q - 4'd1;
               if (drain_q <= 4'd1) begin
                  state_d = ST_HALT;
                  drain_d = '0;
               end
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state, drain counter and halted flag.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q  <= ST_IDLE;
         drain_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         drain_q  <= drain_d;
         halted_q <= (state_d == ST_HALT);
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.stage_en    = stage_en;
   assign bus.stage_flush = stage_flush;
   assign bus.state       = state_q;
   assign bus.halted      = halted_q;

`ifdef PIPE_PERF_COUNTERS_EN
   logic [CNT_W-1:0] cycle_q;
   logic [CNT_W-1:0] stall_q;

   // Debug counters: active cycles and load-use stall cycles, wrapping naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q <= '0;
         stall_q <= '0;
      end else begin
         if (active || (state_q == ST_DRAIN))
            cycle_q <= cycle_q + 1'b1;
         if (active && bus.load_use_hazard && !bus.branch_taken)
            stall_q <= stall_q + 1'b1;
      end
   end

   assign bus.cycle_count = cycle_q;
   assign bus.stall_count = stall_q;
`else
   assign bus.cycle_count = '0;
   assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit (default parameters).
// Each scenario task builds a table of per-cycle stimulus and expected outputs.
// Expectations go to a scoreboard queue as the stimulus is driven and are
// popped and compared at the following falling edge. Counter expectations
// collapse to zero unless PIPE_PERF_COUNTERS_EN is defined.
`timescale 1ns/1ps
module tb_pipeline_control_unit;

   localparam int N  = 5;
   localparam int CW = 32;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_STEP  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   // Stimulus bits: {reset, run, step, pause, load_use, branch, halt_decoded}
   localparam logic [6:0] I_NONE = 7'h00;
   localparam logic [6:0] I_HD   = 7'h01;
   localparam logic [6:0] I_BT   = 7'h02;
   localparam logic [6:0] I_LU   = 7'h04;
   localparam logic [6:0] I_PAU  = 7'h08;
   localparam logic [6:0] I_STP  = 7'h10;
   localparam logic [6:0] I_RUN  = 7'h20;
   localparam logic [6:0] I_RST  = 7'h40;

   typedef struct packed {
      logic          pc;
      logic [N-1:0]  en;
      logic [N-1:0]  fl;
      logic [2:0]    st;
      logic          h;
      logic [CW-1:0] cc;
      logic [CW-1:0] sc;
   } exp_t;

   typedef struct {
      logic [6:0] stim;
      exp_t       e;
   } step_t;

   logic clk = 1'b0;
   logic reset;

   pipeline_control_unit_if #(.N_STAGES(N), .CNT_W(CW)) bus ();

   pipeline_control_unit #(
      .N_STAGES    (N),
      .HOLD_STAGES (2),
      .BRANCH_STAGE(3),
      .CNT_W       (CW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   passed = 0;
   int   total  = 0;

   // ---------------- expectation builders ----------------
   function automatic exp_t mk(logic pc, logic [N-1:0] en, logic [N-1:0] fl,
                               logic [2:0] st, logic h, int cc, int sc);
      exp_t e;
      e.pc = pc; e.en = en; e.fl = fl; e.st = st; e.h = h;
`ifdef PIPE_PERF_COUNTERS_EN
      e.cc = CW'(cc);
      e.sc = CW'(sc);
`else
      e.cc = '0;
      e.sc = '0;
`endif
      return e;
   endfunction

   function automatic exp_t e_idle(int cc, int sc);
      return mk(1'b0, 5'b00000, 5'b00000, S_IDLE, 1'b0, cc, sc);
   endfunction
   function automatic exp_t e_act(logic [2:0] st, int cc, int sc);
      return mk(1'b1, 5'b11111, 5'b00000, st, 1'b0, cc, sc);
   endfunction
   function automatic exp_t e_lu(logic [2:0] st, int cc, int sc);
      return mk(1'b0, 5'b11100, 5'b00100, st, 1'b0, cc, sc);
   endfunction
   function automatic exp_t e_br(logic [2:0] st, int cc, int sc);
      return mk(1'b1, 5'b11111, 5'b00111, st, 1'b0, cc, sc);
   endfunction
   function automatic exp_t e_drain(int cc, int sc);
      return mk(1'b0, 5'b11100, 5'b00100, S_DRAIN, 1'b0, cc, sc);
   endfunction
   function automatic exp_t e_halt(int cc, int sc);
      return mk(1'b0, 5'b00000, 5'b00000, S_HALT, 1'b1, cc, sc);
   endfunction

   function automatic exp_t sample();
      exp_t o;
      o.pc = bus.pc_en;       o.en = bus.stage_en; o.fl = bus.stage_flush;
      o.st = bus.state;       o.h  = bus.halted;
      o.cc = bus.cycle_count; o.sc = bus.stall_count;
      return o;
   endfunction

   function automatic string fmt(exp_t v);
      return $sformatf("pc=%b en=%b fl=%b st=%0d h=%b cc=%0d sc=%0d",
                       v.pc, v.en, v.fl, v.st, v.h, v.cc, v.sc);
   endfunction

   // ---------------- stimulus side ----------------
   task automatic drive(input logic [6:0] s);
      reset               = s[6];
      bus.cmd_run         = s[5];
      bus.cmd_step        = s[4];
      bus.cmd_pause       = s[3];
      bus.load_use_hazard = s[2];
      bus.branch_taken    = s[1];
      bus.halt_decoded    = s[0];
   endtask

   // Drive one cycle of stimulus, queue its expectation, move to the sampling edge.
   task automatic apply(input logic [6:0] s, input exp_t e);
      drive(s);
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(I_RST);
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      step_t seq[$];
      exp_t  got, want;
      do_reset();
      seq.push_back('{I_RST,              e_idle(0, 0)});
      seq.push_back('{I_NONE,             e_idle(0, 0)});
      seq.push_back('{I_LU | I_BT | I_HD, e_idle(0, 0)});
      seq.push_back('{I_PAU | I_STP,      e_idle(0, 0)});
      seq.push_back('{I_NONE,             e_idle(0, 0)});
      foreach (seq[i]) begin
         apply(seq[i].stim, seq[i].e);
         got = sample(); want = sb_q.pop_front(); total++;
         if (got !== want) $display("FAIL reset[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_run();
      step_t seq[$];
      exp_t  got, want;
      do_reset();
      seq.push_back('{I_RUN, e_idle(0, 0)});
      for (int k = 0; k < 10; k++) seq.push_back('{I_NONE, e_act(S_RUN, k, 0)});
      seq.push_back('{I_PAU,  e_act(S_RUN, 10, 0)});
      seq.push_back('{I_NONE, e_idle(11, 0)});
      seq.push_back('{I_NONE, e_idle(11, 0)});
      foreach (seq[i]) begin
         apply(seq[i].stim, seq[i].e);
         got = sample(); want = sb_q.pop_front(); total++;
         if (got !== want) $display("FAIL run[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      step_t seq[$];
      exp_t  got, want;
      do_reset();
      seq.push_back('{I_RUN,       e_idle(0, 0)});
      seq.push_back('{I_NONE,      e_act(S_RUN, 0, 0)});
      seq.push_back('{I_LU,        e_lu(S_RUN, 1, 0)});
      seq.push_back('{I_NONE,      e_act(S_RUN, 2, 1)});
      seq.push_back('{I_LU | I_BT, e_br(S_RUN, 3, 1)});
      seq.push_back('{I_NONE,      e_act(S_RUN, 4, 1)});
      seq.push_back('{I_LU,        e_lu(S_RUN, 5, 1)});
      seq.push_back('{I_LU,        e_lu(S_RUN, 6, 2)});
      seq.push_back('{I_PAU,       e_act(S_RUN, 7, 3)});
      seq.push_back('{I_LU,        e_idle(8, 3)});
      seq.push_back('{I_NONE,      e_idle(8, 3)});
      foreach (seq[i]) begin
         apply(seq[i].stim, seq[i].e);
         got = sample(); want = sb_q.pop_front(); total++;
         if (got !== want) $display("FAIL load_use[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_priority();
      step_t seq[$];
      exp_t  got, want;
      do_reset();
      seq.push_back('{I_PAU | I_RUN | I_STP, e_idle(0, 0)});
      seq.push_back('{I_NONE,                e_idle(0, 0)});
      seq.push_back('{I_RUN | I_STP,         e_idle(0, 0)});
      seq.push_back('{I_NONE,                e_act(S_RUN, 0, 0)});
      seq.push_back('{I_STP,                 e_act(S_RUN, 1, 0)});
      seq.push_back('{I_PAU,                 e_act(S_RUN, 2, 0)});
      seq.push_back('{I_NONE,                e_idle(3, 0)});
      foreach (seq[i]) begin
         apply(seq[i].stim, seq[i].e);
         got = sample(); want = sb_q.pop_front(); total++;
         if (got !== want) $display("FAIL priority[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_step();
      step_t seq[$];
      exp_t  got, want;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         seq.push_back('{I_STP,  e_idle(k, 0)});
         seq.push_back('{I_NONE, e_act(S_STEP, k, 0)});
      end
      seq.push_back('{I_NONE, e_idle(3, 0)});
      // A HALT decoded during a step starts the drain.
      seq.push_back('{I_STP,  e_idle(3, 0)});
      seq.push_back('{I_HD,   e_act(S_STEP, 3, 0)});
      seq.push_back('{I_NONE, e_drain(4, 0)});
      seq.push_back('{I_NONE, e_drain(5, 0)});
      seq.push_back('{I_NONE, e_drain(6, 0)});
      seq.push_back('{I_NONE, e_halt(7, 0)});
      foreach (seq[i]) begin
         apply(seq[i].stim, seq[i].e);
         got = sample(); want = sb_q.pop_front(); total++;
         if (got !== want) $display("FAIL step[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_halt();
      step_t seq[$];
      exp_t  got, want;
      do_reset();
      seq.push_back('{I_RUN,        e_idle(0, 0)});
      seq.push_back('{I_HD | I_BT,  e_br(S_RUN, 0, 0)});
      seq.push_back('{I_NONE,       e_act(S_RUN, 1, 0)});
      seq.push_back('{I_HD,         e_act(S_RUN, 2, 0)});
      seq.push_back('{I_LU | I_PAU, e_drain(3, 0)});
      seq.push_back('{I_STP,        e_drain(4, 0)});
      seq.push_back('{I_NONE,       e_drain(5, 0)});
      seq.push_back('{I_RUN,        e_halt(6, 0)});
      seq.push_back('{I_STP | I_LU, e_halt(6, 0)});
      seq.push_back('{I_NONE,       e_halt(6, 0)});
      foreach (seq[i]) begin
         apply(seq[i].stim, seq[i].e);
         got = sample(); want = sb_q.pop_front(); total++;
         if (got !== want) $display("FAIL halt[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_drain_branch();
      step_t seq[$];
      exp_t  got, want;
      do_reset();
      seq.push_back('{I_RUN,  e_idle(0, 0)});
      seq.push_back('{I_HD,   e_act(S_RUN, 0, 0)});
      seq.push_back('{I_NONE, e_drain(1, 0)});
      seq.push_back('{I_BT,   e_br(S_DRAIN, 2, 0)});
      for (int k = 3; k < 7; k++) seq.push_back('{I_NONE, e_act(S_RUN, k, 0)});
      // A fresh HALT must drain for the full length again.
      seq.push_back('{I_HD,   e_act(S_RUN, 7, 0)});
      seq.push_back('{I_NONE, e_drain(8, 0)});
      seq.push_back('{I_NONE, e_drain(9, 0)});
      seq.push_back('{I_NONE, e_drain(10, 0)});
      seq.push_back('{I_NONE, e_halt(11, 0)});
      foreach (seq[i]) begin
         apply(seq[i].stim, seq[i].e);
         got = sample(); want = sb_q.pop_front(); total++;
         if (got !== want) $display("FAIL drain_branch[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      step_t seq[$];
      exp_t  got, want;
      do_reset();
      seq.push_back('{I_RUN,  e_idle(0, 0)});
      seq.push_back('{I_HD,   e_act(S_RUN, 0, 0)});
      seq.push_back('{I_NONE, e_drain(1, 0)});
      seq.push_back('{I_RST,  e_drain(2, 0)});
      for (int k = 0; k < 4; k++) seq.push_back('{I_NONE, e_idle(0, 0)});
      seq.push_back('{I_STP,        e_idle(0, 0)});
      seq.push_back('{I_RST | I_LU, e_lu(S_STEP, 0, 0)});
      seq.push_back('{I_NONE,       e_idle(0, 0)});
      seq.push_back('{I_RUN,        e_idle(0, 0)});
      seq.push_back('{I_NONE,       e_act(S_RUN, 0, 0)});
      foreach (seq[i]) begin
         apply(seq[i].stim, seq[i].e);
         got = sample(); want = sb_q.pop_front(); total++;
         if (got !== want) $display("FAIL reset_mid[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   // ---------------- sequencing ----------------
   initial begin
      drive(I_RST);
      test_reset();
      test_run();
      test_load_use();
      test_priority();
      test_step();
      test_halt();
      test_drain_branch();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, passed=%0d total=%0d", passed, total);
      $fatal(1);
   end

endmodule
